// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the sequential RV32M multiply/divide unit.
// Build option: MULDIV_REM_CACHE_EN enables the last-division result cache.
package muldiv_seq_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rs1 is treated as signed for every op except MULHU, DIVU, REMU
    function automatic logic f_rs1_signed(input logic [2:0] f3);
        return (f3 != FUNCT3_MULHU) && (f3 != FUNCT3_DIVU) && (f3 != FUNCT3_REMU);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic f_rs2_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) ||
               (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_iter_step.sv
// Combinational UNROLL-bit iteration shared by multiply and divide.
// Multiply: {hi,lo} is the shift-add accumulator, lo holds the remaining
// multiplier bits, b is the multiplicand magnitude.
// Divide: hi is the partial remainder, lo shifts dividend bits out and
// quotient bits in, b is the divisor magnitude.
module muldiv_iter_step #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XLEN:0]   w_part;
    logic [XLEN:0]   w_diff;
    logic [XLEN:0]   w_sum;

    // Unrolled restore-subtract or shift-add iterations
    always_comb begin
        w_hi   = i_hi;
        w_lo   = i_lo;
        w_part = '0;
        w_diff = '0;
        w_sum  = '0;
        for (int unsigned k = 0; k < UNROLL; k++) begin
            if (i_is_div) begin
                w_part = {w_hi, w_lo[XLEN-1]};
                w_diff = w_part - {1'b0, i_b};
                if (!w_diff[XLEN]) begin
                    w_hi = w_diff[XLEN-1:0];
                    w_lo = {w_lo[XLEN-2:0], 1'b1};
                end else begin
                    w_hi = w_part[XLEN-1:0];
                    w_lo = {w_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end
        end
        o_hi = w_hi;
        o_lo = w_lo;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit with valid/ready request and
// response channels, tag passthrough and flush.
// Build option: MULDIV_REM_CACHE_EN keeps the last normally completed
// division so a matching DIV/DIVU/REM/REMU completes in one cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rstLow,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam int unsigned     STEPS   = XLEN / UNROLL;
    localparam int unsigned     CNT_W   = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_rsp_data;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_is_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_data;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_data;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_data;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_data;

    // Operand decode: magnitudes, divide special cases
    assign w_is_div   = funct3_i[2];
    assign w_a_neg    = f_rs1_signed(funct3_i) & rs1_i[XLEN-1];
    assign w_b_neg    = f_rs2_signed(funct3_i) & rs2_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1_i : rs1_i;
    assign w_b_mag    = w_b_neg ? -rs2_i : rs2_i;
    assign w_div_zero = w_is_div & (rs2_i == '0);
    assign w_div_ovf  = w_is_div & ~funct3_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);
    assign w_special  = w_div_zero | w_div_ovf;

    // Divide-by-zero takes priority; funct3[1] selects the remainder
    always_comb begin
        w_special_data = '0;
        if (w_div_zero) w_special_data = funct3_i[1] ? rs1_i : '1;
        else            w_special_data = funct3_i[1] ? '0 : rs1_i;
    end

`ifdef MULDIV_REM_CACHE_EN
    logic            r_c_valid;
    logic            r_c_signed;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_quo;
    logic [XLEN-1:0] r_c_rem;
    logic [XLEN-1:0] r_a_raw;
    logic [XLEN-1:0] r_b_raw;

    assign w_hit      = w_is_div & r_c_valid & (r_c_a == rs1_i) & (r_c_b == rs2_i) &
                        (r_c_signed == ~funct3_i[0]);
    assign w_hit_data = funct3_i[1] ? r_c_rem : r_c_quo;

    // Last-division cache: filled at FIX, cleared by reset and flush
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
            r_a_raw    <= '0;
            r_b_raw    <= '0;
        end else if (flush_i) begin
            r_c_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_raw <= rs1_i;
                r_b_raw <= rs2_i;
            end
            if ((r_state == ST_FIX) && r_op[2]) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= ~r_op[0];
                r_c_a      <= r_a_raw;
                r_c_b      <= r_b_raw;
                r_c_quo    <= w_quo_fix;
                r_c_rem    <= w_rem_fix;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    assign w_fast      = w_special | w_hit;
    assign w_fast_data = w_special ? w_special_data : w_hit_data;

    muldiv_iter_step #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_step (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Sign correction and result selection in FIX
    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -r_lo : r_lo;
    assign w_rem_fix  = r_neg_rem ? -r_hi : r_hi;
    assign w_fix_data = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                                : ((r_op == FUNCT3_MUL) ? w_prod_fix[XLEN-1:0]
                                                        : w_prod_fix[2*XLEN-1:XLEN]);

    // Next-state logic and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & rsp_ready_i);
        w_accept    = req_valid_i & w_req_ready & ~flush_i;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(STEPS - 1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept)         w_state_nxt = w_fast ? ST_DONE : ST_CALC;
                else if (rsp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush_i) w_state_nxt = ST_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Operand latch, iteration datapath and response registers
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_b        <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
        end else if (!flush_i) begin
            if (w_accept) begin
                r_op      <= funct3_i;
                r_rsp_tag <= tag_i;
                r_cnt     <= '0;
                r_hi      <= '0;
                r_lo      <= w_is_div ? w_a_mag : w_b_mag;
                r_b       <= w_is_div ? w_b_mag : w_a_mag;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                if (w_fast) r_rsp_data <= w_fast_data;
            end else if (r_state == ST_CALC) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == ST_FIX) begin
                r_rsp_data <= w_fix_data;
            end
        end
    end

    assign req_ready_o = w_req_ready;
    assign rsp_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state == ST_CALC) | (r_state == ST_FIX);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_tag_o   = r_rsp_tag;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN=32, UNROLL=1).
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
`ifdef MULDIV_REM_CACHE_EN
    localparam int REM_LAT = 1;
`else
    localparam int REM_LAT = 34;
`endif

    logic             clk;
    logic             rstLow;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [TAG_W-1:0] tag_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [XLEN-1:0]  rsp_data_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(
        .XLEN   (XLEN),
        .UNROLL (1),
        .TAG_W  (TAG_W)
    ) dut (
        .clk         (clk),
        .rstLow      (rstLow),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .tag_i       (tag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_tag_o   (rsp_tag_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns 1ns after the accept edge
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg);
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        rs1_i       = a;
        rs2_i       = b;
        tag_i       = tg;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1
    task automatic wait_rsp(input string nm, input logic [31:0] exp_d, input logic [4:0] exp_t,
                            input int exp_lat);
        int lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_data"}, 64'(rsp_data_o), 64'(exp_d));
        chk({nm, "_tag"}, 64'(rsp_tag_o), 64'(exp_t));
    endtask

    task automatic retire(input string nm);
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        chk({nm, "_retired"}, 64'(rsp_valid_o), 64'd0);
    endtask

    task automatic op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp_d,
                      input int exp_lat);
        send(f3, a, b, tg);
        wait_rsp(nm, exp_d, tg, exp_lat);
        retire(nm);
    endtask

    initial begin
        logic seen;
        rstLow      = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        funct3_i    = 3'd0;
        rs1_i       = '0;
        rs2_i       = '0;
        tag_i       = '0;
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", 64'(rsp_data_o), 64'd0);
        chk("rst_tag", 64'(rsp_tag_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstLow = 1'b1;

        op("mul",    FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34);
        op("mulh",   FUNCT3_MULH,   32'd7,        32'hFFFFFFFD, 5'd2,  32'hFFFFFFFF, 34);
        op("mulhu",  FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34);
        op("mulhsu", FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34);
        op("div",    FUNCT3_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34);
        op("rem",    FUNCT3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, REM_LAT);
        op("divu_z", FUNCT3_DIVU,   32'd5,        32'd0,        5'd7,  32'hFFFFFFFF, 1);
        op("remu_z", FUNCT3_REMU,   32'd5,        32'd0,        5'd8,  32'd5,        1);
        op("div_ov", FUNCT3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 1);
        op("rem_ov", FUNCT3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0,        1);

        // Backpressure: response held, then back-to-back accept
        send(FUNCT3_DIVU, 32'd100, 32'd7, 5'd11);
        wait_rsp("hold", 32'd14, 5'd11, 34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_data", 64'(rsp_data_o), 64'd14);
            chk("hold_tag", 64'(rsp_tag_o), 64'd11);
            chk("hold_req_ready", 64'(req_ready_o), 64'd0);
            chk("hold_valid", 64'(rsp_valid_o), 64'd1);
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        funct3_i    = FUNCT3_MUL;
        rs1_i       = 32'd6;
        rs2_i       = 32'd7;
        tag_i       = 5'd12;
        #1;
        chk("b2b_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        chk("b2b_busy", 64'(busy_o), 64'd1);
        chk("b2b_valid", 64'(rsp_valid_o), 64'd0);
        wait_rsp("b2b_mul", 32'd42, 5'd12, 34);
        retire("b2b_mul");

        // Flush in CALC cycle 5 with a competing request
        send(FUNCT3_MUL, 32'd5, 32'd5, 5'd13);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        funct3_i    = FUNCT3_MULHU;
        rs1_i       = 32'd9;
        rs2_i       = 32'd9;
        tag_i       = 5'd14;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_valid", 64'(rsp_valid_o), 64'd0);
        chk("flush_req_ready", 64'(req_ready_o), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o) seen = 1'b1;
        end
        chk("flush_no_rsp", 64'(seen), 64'd0);
        op("rem_post_flush", FUNCT3_REM, 32'hFFFFFFF9, 32'd2, 5'd15, 32'hFFFFFFFF, 34);

        // Asynchronous reset mid-CALC
        send(FUNCT3_DIV, 32'd100, 32'd3, 5'd16);
        repeat (3) @(posedge clk);
        #2;
        rstLow = 1'b0;
        #1;
        chk("arst_req_ready", 64'(req_ready_o), 64'd1);
        chk("arst_valid", 64'(rsp_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_data", 64'(rsp_data_o), 64'd0);
        chk("arst_tag", 64'(rsp_tag_o), 64'd0);
        @(negedge clk);
        rstLow = 1'b1;
        op("remu_post_rst", FUNCT3_REMU, 32'd100, 32'd7, 5'd17, 32'd2, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised, handshaked RISC-V M-extension unit: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands with an iterative shift-add multiplier and a restoring divider, both retiring UNROLL bits per cycle. It sits in the execution stage beside the ALU. It replaces busy-flag polling with valid/ready request and response channels, a tag, and a flush. Only one operation is outstanding at a time.

## Interface
- XLEN, 32, operand/result width; even, ≥8
- UNROLL, 1, quotient/multiplier bits processed per CALC cycle; must divide XLEN
- TAG_W, 5, width of the opaque tag carried request→response (e.g. rd index)

Ports:
- clk  in  1  clock
- rstLow  in  1  reset rstLow, asynchronous, active-low
- flush_i  in  1  synchronous abort of any in-flight or pending operation
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- funct3_i  in  3  RV32M funct3 operation code
- rs1_i  in  XLEN  multiplicand / dividend
- rs2_i  in  XLEN  multiplier / divisor
- tag_i  in  TAG_W  request tag
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer takes result
- rsp_data_o  out  XLEN  result
- rsp_tag_o  out  TAG_W  tag of the request that produced rsp_data_o
- busy_o  out  1  high in CALC or FIX

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE→CALC on accept, where accept = req_valid_i & req_ready_o. Operands and tag are latched on accept.
- Signed operands are converted to magnitudes on accept:
  - rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  - rs2 is signed for MUL, MULH, DIV, REM.
- CALC runs for exactly XLEN/UNROLL cycles:
  - Multiply: 2·XLEN-bit shift-add accumulator.
  - Divide: restoring divide, yielding an XLEN-bit quotient and remainder.
- FIX (1 cycle) applies sign correction and selects the result:
  - Product is negated if the signed-operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- DONE: rsp_valid_o=1. rsp_data_o and rsp_tag_o are held stable until rsp_ready_i.
  - DONE→IDLE on rsp_ready_i.
  - If req_valid_i is also high in that cycle, a new accept happens in the same cycle and the state goes DONE→CALC.
- req_ready_o = (state==IDLE) | (state==DONE & rsp_ready_i). This is a combinational path from rsp_ready_i.
- Special cases skip CALC and FIX; the state goes IDLE→DONE directly:
  - Divisor 0: quotient = all ones, remainder = rs1_i.
  - Signed overflow (rs1 = 1 followed by zeros, rs2 = all ones, DIV/REM only): quotient = rs1_i, remainder = 0.
- flush_i has priority over everything except reset. On the next edge: state=IDLE, rsp_valid_o=0, and the cache is invalidated. A request presented in the same cycle as flush_i is not accepted.
- Reset (asynchronous, any state) returns the unit to IDLE and invalidates the cache.
- Reset values:
  - req_ready_o=1, rsp_valid_o=0, busy_o=0
  - rsp_data_o=0, rsp_tag_o=0
  - all internal registers 0

## Timing
- Normal op: rsp_valid_o rises XLEN/UNROLL+2 edges after the accept edge. For XLEN=32, UNROLL=1 that is 34.
- Special case or cache hit: rsp_valid_o rises 1 edge after accept.
- Throughput: at best one result every XLEN/UNROLL+2 cycles (no overlap of operations).
- busy_o is high in every CALC and FIX cycle, and low in IDLE and DONE.

## Configuration
- MULDIV_REM_CACHE_EN defined:
  - Each normally completed division stores dividend, divisor, signedness, quotient and remainder.
  - A later DIV/DIVU/REM/REMU with identical operands and signedness is a hit: IDLE→DONE with 1-cycle latency.
  - The cache is invalidated on reset and flush_i.
- Undefined: no storage; every non-special division iterates in full.

## Structure
- Shared defines/package holds:
  - FUNCT3_* opcode constants
  - state encoding (IDLE/CALC/FIX/DONE)
  - the XLEN default
- One sub-module, muldiv_iter_step: a combinational UNROLL-bit shift-add / restore-subtract step, instantiated once and shared by multiply and divide.
- Sign conversion, special-case detection, FSM and cache live in muldiv_seq.

## Test plan
All cases use XLEN=32, UNROLL=1.
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB at edge 34. MULH on the same operands → 0xFFFFFFFF. rsp_tag_o equals tag_i.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU on the same operands → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, then REM on the same operands → 0xFFFFFFFF.
  - With MULDIV_REM_CACHE_EN: REM latency is 1.
  - Without it: REM latency is 34.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each at latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- Hold rsp_ready_i low for 10 cycles: rsp_data_o and rsp_tag_o stay stable and req_ready_o stays 0. When rsp_ready_i rises with req_valid_i high, the next request is accepted in the same cycle.
- flush_i in CALC cycle 5 → IDLE next edge, no response, req_ready_o=1. rstLow pulsed mid-CALC → all outputs return to their reset values immediately.
